// File: rtl/coin_dispenser.sv
// coin_dispenser: payout side of the coin vending datapath.
// Pays a change amount (0..99 cents) as a sequence of single coins, greedy
// largest-first (25, 10, 5, 1), skipping any denomination whose inventory is
// empty. Coins are offered to the ejector with a valid/ready handshake.
//
// Ports:
//   MAX10_CLK1_50  system clock, rising edge
//   rst_n          asynchronous active-low reset
//   load, amount   start request and change to pay (sampled only in IDLE)
//   busy           high whenever the FSM is not IDLE (decoded from state)
//   coin_valid     coin offered to the ejector
//   coin_sel       one-hot denomination {25,10,5,1}; 0000 when not offering
//   coin_ready     ejector accepts the offered coin
//   remaining      cents still owed
//   done           one-cycle pulse at the end of every payout
//   short          sticky: last payout ran out of usable coins
//   err            sticky: last load request had amount > 99
//   inv            inventory counts {n25,n10,n5,n1}, 4 bits each
module coin_dispenser #(
  parameter int INV_1  = 15,
  parameter int INV_5  = 15,
  parameter int INV_10 = 15,
  parameter int INV_25 = 15
) (
  input  logic        MAX10_CLK1_50,
  input  logic        rst_n,
  input  logic        load,
  input  logic [6:0]  amount,
  output logic        busy,
  output logic        coin_valid,
  output logic [3:0]  coin_sel,
  input  logic        coin_ready,
  output logic [6:0]  remaining,
  output logic        done,
  output logic        short,
  output logic        err,
  output logic [15:0] inv
);

  typedef enum logic [1:0] {IDLE, SELECT, OFFER, DONE} state_t;

  state_t     state, state_n;
  logic [6:0] remaining_n;
  logic [3:0] coin_sel_n;
  logic       coin_valid_n, done_n, short_n, err_n;
  // cnt[0]=1c, cnt[1]=5c, cnt[2]=10c, cnt[3]=25c (same bit order as coin_sel)
  logic [3:0] cnt   [4];
  logic [3:0] cnt_n [4];
  logic [3:0] pick;
  logic [6:0] coin_val;

  assign busy = (state != IDLE);
  assign inv  = {cnt[3], cnt[2], cnt[1], cnt[0]};

  // Greedy pick: largest denomination that fits and is still stocked.
  always_comb begin
    pick = 4'b0000;
    if      (remaining >= 7'd25 && cnt[3] != 4'd0) pick = 4'b1000;
    else if (remaining >= 7'd10 && cnt[2] != 4'd0) pick = 4'b0100;
    else if (remaining >= 7'd5  && cnt[1] != 4'd0) pick = 4'b0010;
    else if (remaining >= 7'd1  && cnt[0] != 4'd0) pick = 4'b0001;
  end

  always_comb begin
    unique case (coin_sel)
      4'b1000: coin_val = 7'd25;
      4'b0100: coin_val = 7'd10;
      4'b0010: coin_val = 7'd5;
      4'b0001: coin_val = 7'd1;
      default: coin_val = 7'd0;
    endcase
  end

  always_comb begin
    state_n      = state;
    remaining_n  = remaining;
    coin_sel_n   = coin_sel;
    coin_valid_n = coin_valid;
    done_n       = 1'b0;
    short_n      = short;
    err_n        = err;
    for (int i = 0; i < 4; i++) cnt_n[i] = cnt[i];

    unique case (state)
      IDLE: begin
        if (load) begin
          if (amount > 7'd99) begin
            err_n = 1'b1;
          end else begin
            remaining_n = amount;
            short_n     = 1'b0;
            err_n       = 1'b0;
            state_n     = SELECT;
          end
        end
      end
      SELECT: begin
        if (remaining == 7'd0) begin
          done_n  = 1'b1;
          state_n = DONE;
        end else if (pick != 4'b0000) begin
          coin_sel_n   = pick;
          coin_valid_n = 1'b1;
          state_n      = OFFER;
        end else begin
          short_n = 1'b1;
          done_n  = 1'b1;
          state_n = DONE;
        end
      end
      OFFER: begin
        if (coin_valid && coin_ready) begin
          // Selection guaranteed coin_val <= remaining and cnt > 0.
          remaining_n = remaining - coin_val;
          for (int i = 0; i < 4; i++)
            if (coin_sel[i]) cnt_n[i] = cnt[i] - 4'd1;
          coin_valid_n = 1'b0;
          coin_sel_n   = 4'b0000;
          state_n      = SELECT;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= '0;
      coin_sel   <= '0;
      coin_valid <= 1'b0;
      done       <= 1'b0;
      short      <= 1'b0;
      err        <= 1'b0;
      cnt[0]     <= 4'(INV_1);
      cnt[1]     <= 4'(INV_5);
      cnt[2]     <= 4'(INV_10);
      cnt[3]     <= 4'(INV_25);
    end else begin
      state      <= state_n;
      remaining  <= remaining_n;
      coin_sel   <= coin_sel_n;
      coin_valid <= coin_valid_n;
      done       <= done_n;
      short      <= short_n;
      err        <= err_n;
      for (int i = 0; i < 4; i++) cnt[i] <= cnt_n[i];
    end
  end

endmodule

// File: tb/tb_coin_dispenser.sv
// Directed bench for coin_dispenser. Three instances share clock, reset,
// amount and coin_ready; each has its own load: A uses default inventory,
// B has a single 25c coin, C has no 1c coins.
module tb_coin_dispenser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_ready;
  logic [6:0] amount;
  logic       load_a, load_b, load_c;

  logic        busy_a, cv_a, done_a, short_a, err_a;
  logic [3:0]  sel_a;
  logic [6:0]  rem_a;
  logic [15:0] inv_a;
  logic        busy_b, cv_b, done_b, short_b, err_b;
  logic [3:0]  sel_b;
  logic [6:0]  rem_b;
  logic [15:0] inv_b;
  logic        busy_c, cv_c, done_c, short_c, err_c;
  logic [3:0]  sel_c;
  logic [6:0]  rem_c;
  logic [15:0] inv_c;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  coin_dispenser dut_a (
    .MAX10_CLK1_50(clk), .rst_n(rst_n), .load(load_a), .amount(amount),
    .busy(busy_a), .coin_valid(cv_a), .coin_sel(sel_a), .coin_ready(coin_ready),
    .remaining(rem_a), .done(done_a), .short(short_a), .err(err_a), .inv(inv_a));

  coin_dispenser #(.INV_25(1)) dut_b (
    .MAX10_CLK1_50(clk), .rst_n(rst_n), .load(load_b), .amount(amount),
    .busy(busy_b), .coin_valid(cv_b), .coin_sel(sel_b), .coin_ready(coin_ready),
    .remaining(rem_b), .done(done_b), .short(short_b), .err(err_b), .inv(inv_b));

  coin_dispenser #(.INV_1(0)) dut_c (
    .MAX10_CLK1_50(clk), .rst_n(rst_n), .load(load_c), .amount(amount),
    .busy(busy_c), .coin_valid(cv_c), .coin_sel(sel_c), .coin_ready(coin_ready),
    .remaining(rem_c), .done(done_c), .short(short_c), .err(err_c), .inv(inv_c));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and settle away from the edge.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  logic [3:0] seq1 [7] = '{4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001, 4'b0001};
  logic [3:0] seq2 [5] = '{4'b1000, 4'b0100, 4'b0100, 4'b0100, 4'b0010};

  initial begin
    rst_n = 1'b0; coin_ready = 1'b1; amount = '0;
    load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
    #12;
    // Reset state
    chk("rst_busy", 16'(busy_a), 16'h0);
    chk("rst_valid", 16'(cv_a), 16'h0);
    chk("rst_sel", 16'(sel_a), 16'h0);
    chk("rst_rem", 16'(rem_a), 16'h0);
    chk("rst_flags", {13'h0, done_a, short_a, err_a}, 16'h0);
    chk("rst_inv_a", inv_a, 16'hFFFF);
    chk("rst_inv_b", inv_b, 16'h1FFF);
    chk("rst_inv_c", inv_c, 16'hFFF0);
    rst_n = 1'b1;
    cyc();

    // 68 cents, default inventory; a stray load at cycle 3 must be ignored
    amount = 7'd68; load_a = 1'b1;
    cyc(); load_a = 1'b0;
    for (int c = 2; c <= 16; c++) begin
      if (c == 3) begin load_a = 1'b1; amount = 7'd99; end
      cyc();
      load_a = 1'b0;
      if (c[0] == 1'b0 && c <= 14) begin
        chk($sformatf("t68_valid_c%0d", c), 16'(cv_a), 16'h1);
        chk($sformatf("t68_sel_c%0d", c), 16'(sel_a), 16'(seq1[(c-2)/2]));
      end else begin
        chk($sformatf("t68_idle_sel_c%0d", c), {11'h0, cv_a, sel_a}, 16'h0);
      end
      chk($sformatf("t68_done_c%0d", c), 16'(done_a), (c == 16) ? 16'h1 : 16'h0);
      chk($sformatf("t68_busy_c%0d", c), 16'(busy_a), 16'h1);
    end
    chk("t68_rem", 16'(rem_a), 16'h0);
    chk("t68_inv", inv_a, 16'hDEEC);
    chk("t68_short", 16'(short_a), 16'h0);
    cyc();
    chk("t68_idle", {15'h0, busy_a}, 16'h0);

    // 60 cents with a single 25c coin
    amount = 7'd60; load_b = 1'b1;
    cyc(); load_b = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      cyc();
      if (c[0] == 1'b0 && c <= 10)
        chk($sformatf("t60_sel_c%0d", c), {11'h0, cv_b, sel_b}, {11'h0, 1'b1, seq2[(c-2)/2]});
      chk($sformatf("t60_done_c%0d", c), 16'(done_b), (c == 12) ? 16'h1 : 16'h0);
    end
    chk("t60_inv", inv_b, 16'h0CEF);
    chk("t60_short", 16'(short_b), 16'h0);
    chk("t60_rem", 16'(rem_b), 16'h0);
    cyc();

    // 3 cents with no 1c coins: short, nothing dispensed
    amount = 7'd3; load_c = 1'b1;
    cyc(); load_c = 1'b0;
    chk("t3_valid_c1", 16'(cv_c), 16'h0);
    cyc();
    chk("t3_valid_c2", 16'(cv_c), 16'h0);
    chk("t3_done_c2", 16'(done_c), 16'h1);
    chk("t3_short", 16'(short_c), 16'h1);
    chk("t3_rem", 16'(rem_c), 16'h3);
    chk("t3_inv", inv_c, 16'hFFF0);
    cyc();
    chk("t3_done_c3", 16'(done_c), 16'h0);
    cyc();

    // Backpressure: ready low for 5 cycles after valid
    coin_ready = 1'b0; amount = 7'd25; load_a = 1'b1;
    cyc(); load_a = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      cyc();
      if (c == 7) coin_ready = 1'b1;
      chk($sformatf("bp_hold_c%0d", c), {11'h0, cv_a, sel_a}, 16'h0018);
      chk($sformatf("bp_rem_c%0d", c), 16'(rem_a), 16'd25);
    end
    cyc();
    chk("bp_valid_c8", 16'(cv_a), 16'h0);
    chk("bp_rem_c8", 16'(rem_a), 16'h0);
    cyc();
    chk("bp_done_c9", 16'(done_a), 16'h1);
    chk("bp_inv", inv_a, 16'hCEEC);
    cyc();

    // Out-of-range load, then a valid one clears err
    amount = 7'd100; load_a = 1'b1;
    cyc(); load_a = 1'b0;
    chk("e100_err", 16'(err_a), 16'h1);
    chk("e100_busy_c1", 16'(busy_a), 16'h0);
    cyc();
    chk("e100_busy_c2", 16'(busy_a), 16'h0);
    chk("e100_done_c2", 16'(done_a), 16'h0);
    chk("e100_rem", 16'(rem_a), 16'h0);
    amount = 7'd5; load_a = 1'b1;
    cyc(); load_a = 1'b0;
    chk("e5_err", 16'(err_a), 16'h0);
    chk("e5_busy", 16'(busy_a), 16'h1);
    cyc();
    chk("e5_coin", {11'h0, cv_a, sel_a}, 16'h0012);
    cyc(); cyc();
    chk("e5_done", 16'(done_a), 16'h1);
    chk("e5_inv", inv_a, 16'hCEDC);
    cyc();

    // Reset in the middle of an OFFER of a 25c coin
    coin_ready = 1'b0; amount = 7'd25; load_a = 1'b1;
    cyc(); load_a = 1'b0;
    cyc(); cyc();
    chk("rm_offer", {11'h0, cv_a, sel_a}, 16'h0018);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_async_valid", {11'h0, cv_a, sel_a}, 16'h0);
    chk("rm_async_inv", inv_a, 16'hFFFF);
    #8 rst_n = 1'b1; coin_ready = 1'b1;
    cyc();
    chk("rm_busy", 16'(busy_a), 16'h0);
    chk("rm_rem", 16'(rem_a), 16'h0);
    chk("rm_inv", inv_a, 16'hFFFF);
    chk("rm_valid", 16'(cv_a), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/coin_dispenser.md
Name: coin_dispenser

Overview:
- Payout side of the coin vending datapath: takes a change amount (0..99 cents) and dispenses it as individual coins to a coin-ejector mechanism.
- Uses greedy largest-first selection: 25, 10, 5, 1. Skips any denomination whose on-board inventory is empty.
- Coin encoding is one-hot, identical to the deposit switch encoding: 0001=1, 0010=5, 0100=10, 1000=25.
- Sits between the balance register and the ejector. Inventory counters also drive LED/HEX status.

Parameters:
- INV_1, 15, initial count of 1-cent coins (0..15).
- INV_5, 15, initial count of 5-cent coins (0..15).
- INV_10, 15, initial count of 10-cent coins (0..15).
- INV_25, 15, initial count of 25-cent coins (0..15).

Ports:
- MAX10_CLK1_50  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  start request; sampled only in IDLE.
- amount  in  7  change to pay, unsigned.
- busy  out  1  high in any state other than IDLE.
- coin_valid  out  1  coin offered to the ejector.
- coin_sel  out  4  one-hot denomination of the offered coin; 0000 when not offering.
- coin_ready  in  1  ejector accepts the coin.
- remaining  out  7  cents still owed.
- done  out  1  one-cycle pulse at the end of every payout.
- short  out  1  sticky: the last payout could not complete.
- err  out  1  sticky: the last load request had amount>99.
- inv  out  16  inventory counts {n25,n10,n5,n1}, 4 bits each.

Behaviour:
- Reset (async, while rst_n=0):
  - state=IDLE; remaining=0; coin_valid=0; coin_sel=0000; done=0; short=0; err=0.
  - inv reloaded from the INV_* parameters.
- States: IDLE, SELECT, OFFER, DONE. All outputs are registered except busy, which is decoded from state.
- IDLE:
  - load=1 and amount<=99: remaining<=amount; short<=0; err<=0; go to SELECT.
  - load=1 and amount>99: err<=1; remaining unchanged; stay in IDLE; no done pulse.
- SELECT (exactly 1 cycle):
  - remaining==0: go to DONE.
  - Otherwise pick the largest d in {25,10,5,1} with d<=remaining and inv[d]>0; latch coin_sel; go to OFFER.
  - No such d: short<=1; go to DONE.
- OFFER:
  - coin_valid=1; coin_sel held stable.
  - coin_valid&&coin_ready in a cycle: remaining<=remaining-d; inv[d]<=inv[d]-1; coin_valid drops; go to SELECT.
  - coin_ready low: hold indefinitely (no timeout).
- DONE: done=1 for exactly one cycle; go to IDLE.
- load while busy: ignored, not queued.
- Latency, with coin_ready held high and load in cycle 0:
  - first coin_valid in cycle 2;
  - each coin costs 2 cycles (OFFER + SELECT);
  - done in cycle 2N+2 for N coins.
- amount=0: done in cycle 2; no coins.
- Arithmetic: remaining never underflows, because d<=remaining is guaranteed. Inventory never underflows, because inv[d]>0 is checked before selection.
- short=1 leaves remaining = unpaid cents. Coins already dispensed are not recovered.
- Reset mid-OFFER: coin_valid drops asynchronously. The in-flight coin is not counted.

Test Plan:
- Default inventory; amount=68, coin_ready=1, load pulse in cycle 0 -> coin_sel sequence 1000,1000,0100,0010,0001,0001,0001 in cycles 2,4,...,14; done in cycle 16; remaining=0; inv={13,14,14,12}.
- INV_25=1; amount=60 -> coins 25,10,10,10,5; inv n25=0; short=0.
- INV_1=0; amount=3 -> no coin_valid; done in cycle 2; short=1; remaining=3.
- Backpressure: amount=25, coin_ready low for 5 cycles after valid -> coin_valid and coin_sel=1000 stable for those cycles; handshake on the first cycle with ready=1; remaining=0.
- amount=100 load -> err=1; busy stays 0; no done. Next load with amount=5 clears err and pays 0010.
- rst_n low during OFFER of a 1000 coin -> coin_valid=0 immediately; after release inv={15,15,15,15}, state IDLE, remaining=0.
